// File: rtl/fpu_mds_issue_if.sv
// Request/response channel between the FPU pipeline and the mul/div/sqrt issue front-end.
// The issue block is the slave; the pipeline (or a bench) is the master.
interface fpu_mds_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_code;
    logic [2:0]  rm_in;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_flags;

    modport master (
        output req_valid, op_a, op_b, op_code, rm_in, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flags
    );

    modport slave (
        input  req_valid, op_a, op_b, op_code, rm_in, resp_ready,
        output req_ready, resp_valid, resp_result, resp_flags
    );
endinterface

// File: rtl/fpu_mds_issue.sv
// Operand unpack/classify front-end and issue sequencer for the FPU mul/div/sqrt core.
// Buffers one response and keeps sticky fflags plus a sticky timeout indication.
module fpu_mds_issue #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    fpu_mds_issue_if.slave bus_io,
    output logic        mds_start_o,
    output logic [1:0]  mds_op_o,
    output logic [2:0]  rounding_mode_o,
    output logic        sign_a_o,
    output logic        sign_b_o,
    output logic [7:0]  exp_a_o,
    output logic [7:0]  exp_b_o,
    output logic [23:0] sig_a_o,
    output logic [23:0] sig_b_o,
    output logic        is_zero_a_o,
    output logic        is_zero_b_o,
    output logic        is_inf_a_o,
    output logic        is_inf_b_o,
    output logic        is_nan_a_o,
    output logic        is_nan_b_o,
    output logic        is_signaling_o,
    output logic        subnormal_sqrt_in_o,
    input  logic        mds_done_i,
    input  logic [31:0] mds_result_i,
    input  logic [4:0]  mds_flags_i,
    output logic [4:0]  fflags_o,
    input  logic        fflags_clr_i,
    output logic        timeout_err_o
);

    localparam logic [31:0]      QNan    = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        zero;
        logic        inf;
        logic        nan;
        logic        snan;
    } opnd_t;

    function automatic opnd_t decode(input logic [31:0] x);
        opnd_t d;
        d.sign = x[31];
        d.zero = (x[30:23] == 8'h00) && (x[22:0] == 23'd0);
        d.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        d.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        d.snan = d.nan && !x[22];
        d.sig  = {x[30:23] != 8'h00, x[22:0]};
        // Subnormals use the minimum effective exponent of 1.
        d.exp  = ((x[30:23] == 8'h00) && (x[22:0] != 23'd0)) ? 8'd1 : x[30:23];
        return d;
    endfunction

    opnd_t       dec_a, dec_b, a_q, b_q;
    logic        is_sig_d, sub_sqrt_d;
    state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic        req_ready_q, mds_start_q, resp_valid_q, is_sig_q, sub_sqrt_q, tmo_q;
    logic [1:0]  op_q;
    logic [2:0]  rm_q;
    logic [31:0] result_q;
    logic [4:0]  flags_q, fflags_q;

    always_comb begin
        dec_a      = decode(bus_io.op_a);
        dec_b      = decode(bus_io.op_b);
        is_sig_d   = dec_a.snan | ((bus_io.op_code != 2'b10) & dec_b.snan);
        sub_sqrt_d = (bus_io.op_code == 2'b10) && (bus_io.op_a[30:23] == 8'h00)
                     && (bus_io.op_a[22:0] != 23'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            mds_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            is_sig_q     <= 1'b0;
            sub_sqrt_q   <= 1'b0;
            op_q         <= '0;
            rm_q         <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            fflags_q     <= '0;
            tmo_q        <= 1'b0;
        end else begin
            mds_start_q <= 1'b0;
            // Later assignments below override this, so clear takes effect before any OR/set.
            if (fflags_clr_i) begin
                fflags_q <= '0;
                tmo_q    <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_ready_q && bus_io.req_valid) begin
                        req_ready_q <= 1'b0;
                        a_q         <= dec_a;
                        b_q         <= dec_b;
                        is_sig_q    <= is_sig_d;
                        sub_sqrt_q  <= sub_sqrt_d;
                        op_q        <= bus_io.op_code;
                        rm_q        <= bus_io.rm_in;
                        if (bus_io.op_code == 2'b11) begin
                            resp_valid_q <= 1'b1;
                            result_q     <= QNan;
                            flags_q      <= 5'b10000;
                            state_q      <= StResp;
                        end else begin
                            mds_start_q <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (mds_done_i) begin
                        resp_valid_q <= 1'b1;
                        result_q     <= mds_result_i;
                        flags_q      <= mds_flags_i;
                        state_q      <= StResp;
                    end else if (cnt_q == CntLast) begin
                        resp_valid_q <= 1'b1;
                        result_q     <= QNan;
                        flags_q      <= 5'b00000;
                        tmo_q        <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (bus_io.resp_ready) begin
                        fflags_q     <= (fflags_clr_i ? 5'b00000 : fflags_q) | flags_q;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.req_ready   = req_ready_q;
    assign bus_io.resp_valid  = resp_valid_q;
    assign bus_io.resp_result = result_q;
    assign bus_io.resp_flags  = flags_q;

    assign mds_start_o         = mds_start_q;
    assign mds_op_o            = op_q;
    assign rounding_mode_o     = rm_q;
    assign sign_a_o            = a_q.sign;
    assign sign_b_o            = b_q.sign;
    assign exp_a_o             = a_q.exp;
    assign exp_b_o             = b_q.exp;
    assign sig_a_o             = a_q.sig;
    assign sig_b_o             = b_q.sig;
    assign is_zero_a_o         = a_q.zero;
    assign is_zero_b_o         = b_q.zero;
    assign is_inf_a_o          = a_q.inf;
    assign is_inf_b_o          = b_q.inf;
    assign is_nan_a_o          = a_q.nan;
    assign is_nan_b_o          = b_q.nan;
    assign is_signaling_o      = is_sig_q;
    assign subnormal_sqrt_in_o = sub_sqrt_q;
    assign fflags_o            = fflags_q;
    assign timeout_err_o       = tmo_q;

endmodule
